// File: rtl/upro_pkg.sv
// Shared definitions for the am2910 microcode fetch stage: microword layout,
// fixed RESET/BUBBLE words and the fetch FSM state type.
package upro_pkg;

   localparam int UWORD_W   = 23;
   localparam int Y_W       = 12;

   localparam int STLAT_BIT = 22;
   localparam int I_MSB     = 21;
   localparam int I_LSB     = 18;
   localparam int CCEN_BIT  = 17;
   localparam int CCSEL_MSB = 16;
   localparam int CCSEL_LSB = 15;
   localparam int CCPOL_BIT = 14;
   localparam int RLD_BIT   = 13;
   localparam int CI_BIT    = 12;
   localparam int D_MSB     = 11;
   localparam int D_LSB     = 0;

   localparam logic [3:0] I_CONT = 4'd14;

   typedef struct packed {
      logic        stlat;
      logic [3:0]  i;
      logic        ccen_b;
      logic [1:0]  ccsel;
      logic        ccpol;
      logic        rld_b;
      logic        ci;
      logic [11:0] d;
   } uword_t;

   // Sequencer sees JZ with CC ignored and no counter load: clears uPC/sp.
   localparam uword_t RESET_WORD = '{stlat: 1'b0, i: 4'd0, ccen_b: 1'b1,
                                     ccsel: 2'd0, ccpol: 1'b0, rld_b: 1'b1,
                                     ci: 1'b0, d: 12'd0};

   // CONT with CI=0 keeps uPC, RE and stack untouched while frozen.
   localparam uword_t BUBBLE_WORD = '{stlat: 1'b0, i: I_CONT, ccen_b: 1'b1,
                                      ccsel: 2'd0, ccpol: 1'b0, rld_b: 1'b1,
                                      ci: 1'b0, d: 12'd0};

   typedef enum logic [1:0] {
      RST  = 2'd0,
      BOOT = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } state_t;

   function automatic logic cc_eval(input logic [3:0] status, input uword_t w);
      return ~(status[w.ccsel] ^ w.ccpol);
   endfunction

endpackage

// File: rtl/upro_store.sv
// Writable microcode store: single write port, registered read with enable.
// Contents are not touched by reset.
module upro_store #(
   parameter int AW = 6,
   parameter int W  = 23
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/upro_fetch_pipe.sv
// Microcode fetch + pipeline register for the am2910 sequencer, with status
// condition-code mux, hold/bubble freeze and a hold-only microcode load port.
//
// state | meaning
// RST   | in reset; RESET_WORD presented
// BOOT  | one cycle of RESET_WORD so the sequencer clears uPC/sp
// RUN   | pipeline word presented, fetch at every edge unless hold
// HOLD  | BUBBLE presented, pipe retained, store writable
module upro_fetch_pipe
   import upro_pkg::*;
#(
   parameter int AW     = 6,
   parameter int WORD_W = UWORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [11:0]       Y,
   input  logic [3:0]        status_in,
   input  logic              hold,
   input  logic              ld_en,
   input  logic [AW-1:0]     ld_addr,
   input  logic [WORD_W-1:0] ld_data,
   output logic [3:0]        I,
   output logic              CCEN_BAR,
   output logic              CC_BAR,
   output logic              RLD_BAR,
   output logic              CI,
   output logic [11:0]       D,
   output logic              ld_ack,
   output logic              oob_err,
   output logic              held
);

   state_t state_q, state_d;

   logic              word_vld_q, word_vld_d;
   logic [3:0]        status_q, status_d;
   logic              oob_q, oob_d;
   logic              ld_ack_q, ld_ack_d;

   logic              y_oob;
   logic              fetch_en;
   logic              wr_en;
   logic [WORD_W-1:0] rd_data;
   uword_t            pipe_w;

   assign y_oob = |Y[Y_W-1:AW];

   upro_store #(
      .AW (AW),
      .W  (WORD_W)
   ) u_store (
      .clk   (clk),
      .we    (wr_en),
      .waddr (ld_addr),
      .wdata (ld_data),
      .re    (fetch_en),
      .raddr (Y[AW-1:0]),
      .rdata (rd_data)
   );

   // The store's read register is the pipe; word_vld_q selects it over RESET_WORD.
   assign pipe_w = word_vld_q ? uword_t'(rd_data) : RESET_WORD;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RST;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RST:  state_d = BOOT;
         BOOT: state_d = RUN;
         RUN:  if (hold) state_d = HOLD;
         HOLD: if (!hold) state_d = RUN;
      endcase
   end

   always_comb begin
      I        = RESET_WORD.i;
      CCEN_BAR = RESET_WORD.ccen_b;
      RLD_BAR  = RESET_WORD.rld_b;
      CI       = RESET_WORD.ci;
      D        = RESET_WORD.d;
      CC_BAR   = 1'b1;
      case (state_q)
         RUN: begin
            I        = pipe_w.i;
            CCEN_BAR = pipe_w.ccen_b;
            RLD_BAR  = pipe_w.rld_b;
            CI       = pipe_w.ci;
            D        = pipe_w.d;
            CC_BAR   = cc_eval(status_q, pipe_w);
         end
         HOLD: begin
            I        = BUBBLE_WORD.i;
            CCEN_BAR = BUBBLE_WORD.ccen_b;
            RLD_BAR  = BUBBLE_WORD.rld_b;
            CI       = BUBBLE_WORD.ci;
            D        = BUBBLE_WORD.d;
         end
         default: ;
      endcase
   end

   assign held    = (state_q == HOLD);
   assign ld_ack  = ld_ack_q;
   assign oob_err = oob_q;

   always_comb begin
      fetch_en   = 1'b0;
      word_vld_d = word_vld_q;
      status_d   = status_q;
      oob_d      = oob_q;
      wr_en      = 1'b0;
      case (state_q)
         BOOT: begin
            fetch_en   = 1'b1;
            word_vld_d = 1'b1;
         end
         RUN: begin
            if (pipe_w.stlat) begin
               status_d = status_in;
            end
            if (!hold) begin
               fetch_en   = !y_oob;
               word_vld_d = !y_oob;
               oob_d      = oob_q | y_oob;
            end
         end
         HOLD: wr_en = hold & ld_en;
         default: word_vld_d = 1'b0;
      endcase
      ld_ack_d = wr_en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_vld_q <= 1'b0;
         status_q   <= 4'd0;
         oob_q      <= 1'b0;
         ld_ack_q   <= 1'b0;
      end else begin
         word_vld_q <= word_vld_d;
         status_q   <= status_d;
         oob_q      <= oob_d;
         ld_ack_q   <= ld_ack_d;
      end
   end

endmodule

// File: tb/tb_upro_fetch_pipe.sv
// Bench for upro_fetch_pipe: directed literal checks followed by randomized
// traffic compared every cycle against a behavioural model of the fetch stage.
module tb_upro_fetch_pipe;

   localparam int AW = 6;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic [11:0]   Y         = '0;
   logic [3:0]    status_in = '0;
   logic          hold      = 1'b0;
   logic          ld_en     = 1'b0;
   logic [AW-1:0] ld_addr   = '0;
   logic [22:0]   ld_data   = '0;

   logic [3:0]  I;
   logic        CCEN_BAR, CC_BAR, RLD_BAR, CI;
   logic [11:0] D;
   logic        ld_ack, oob_err, held;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   upro_fetch_pipe #(.AW(AW), .WORD_W(23)) dut (
      .clk       (clk),
      .rst       (rst),
      .Y         (Y),
      .status_in (status_in),
      .hold      (hold),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .I         (I),
      .CCEN_BAR  (CCEN_BAR),
      .CC_BAR    (CC_BAR),
      .RLD_BAR   (RLD_BAR),
      .CI        (CI),
      .D         (D),
      .ld_ack    (ld_ack),
      .oob_err   (oob_err),
      .held      (held)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [22:0] mkw(input logic st, input logic [3:0] i, input logic ccen,
                                       input logic [1:0] sel, input logic pol, input logic rld,
                                       input logic ci, input logic [11:0] d);
      return {st, i, ccen, sel, pol, rld, ci, d};
   endfunction

   // Behavioural model: mode 0 reset, 1 boot, 2 running, 3 frozen.
   logic [22:0] m_mem [64] = '{default: '0};
   int          m_mode   = 0;
   logic [22:0] m_word   = 23'h0;
   logic [3:0]  m_status = 4'h0;
   bit          m_oob    = 1'b0;
   bit          m_ack    = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode   = 0;
         m_word   = mkw(0, 0, 1, 0, 0, 1, 0, 0);
         m_status = 0;
         m_oob    = 0;
         m_ack    = 0;
      end else begin
         m_ack = 0;
         if (m_mode == 0) begin
            m_mode = 1;
         end else if (m_mode == 1) begin
            m_word = m_mem[Y[5:0]];
            m_mode = 2;
         end else if (m_mode == 2) begin
            if (m_word[22]) m_status = status_in;
            if (hold) m_mode = 3;
            else if (Y >= 12'd64) begin
               m_word = mkw(0, 0, 1, 0, 0, 1, 0, 0);
               m_oob  = 1;
            end else m_word = m_mem[Y[5:0]];
         end else begin
            if (hold && ld_en) begin
               m_mem[ld_addr] = ld_data;
               m_ack = 1;
            end
            if (!hold) m_mode = 2;
         end
      end
   end

   always @(negedge clk) begin : cmp
      logic [3:0]  ei;
      logic [11:0] ed;
      logic        eccen, ecc, erld, eci;
      if (chk_en) begin
         if (m_mode == 2) begin
            ei    = m_word[21:18];
            eccen = m_word[17];
            erld  = m_word[13];
            eci   = m_word[12];
            ed    = m_word[11:0];
            ecc   = ~(m_status[m_word[16:15]] ^ m_word[14]);
         end else begin
            ei    = (m_mode == 3) ? 4'd14 : 4'd0;
            eccen = 1'b1;
            erld  = 1'b1;
            eci   = 1'b0;
            ed    = 12'd0;
            ecc   = 1'b1;
         end
         chk("I", I, ei);
         chk("CCEN_BAR", CCEN_BAR, eccen);
         chk("CC_BAR", CC_BAR, ecc);
         chk("RLD_BAR", RLD_BAR, erld);
         chk("CI", CI, eci);
         chk("D", D, ed);
         chk("ld_ack", ld_ack, m_ack);
         chk("oob_err", oob_err, m_oob);
         chk("held", held, m_mode == 3);
      end
   end

   task automatic cyc(input logic [11:0] y, input logic h, input logic le,
                      input logic [AW-1:0] la, input logic [22:0] ld);
      Y       = y;
      hold    = h;
      ld_en   = le;
      ld_addr = la;
      ld_data = ld;
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [22:0] w5, w3, w4, w7, w9, w10;
      w5  = mkw(0, 14, 0, 0, 0, 0, 1, 12'h0AB);
      w3  = mkw(1, 1, 0, 2, 0, 1, 0, 12'h003);
      w4  = mkw(0, 2, 0, 2, 0, 1, 0, 12'h004);
      w7  = mkw(0, 5, 0, 0, 0, 0, 0, 12'h123);
      w9  = mkw(0, 8, 1, 0, 0, 1, 0, 12'h055);
      w10 = mkw(0, 3, 0, 0, 0, 0, 1, 12'h777);

      repeat (3) @(negedge clk);
      #1;
      chk_en = 1'b1;
      chk("rst_I", I, 0);
      chk("rst_held", held, 0);
      rst = 1'b0;

      cyc(0, 0, 0, 0, 0);
      chk("boot_I", I, 0);
      chk("boot_CCEN", CCEN_BAR, 1);
      cyc(0, 0, 0, 0, 0);
      chk("run0_I", I, 0);
      chk("run0_CCEN", CCEN_BAR, 0);

      cyc(0, 1, 0, 0, 0);
      chk("hold_I", I, 14);
      chk("hold_held", held, 1);
      chk("hold_CC", CC_BAR, 1);
      cyc(0, 1, 1, 5, w5);
      chk("ld_ack5", ld_ack, 1);
      chk("hold_I2", I, 14);
      cyc(0, 0, 0, 0, 0);
      chk("rel_I", I, 0);
      chk("rel_ack", ld_ack, 0);
      cyc(5, 0, 0, 0, 0);
      chk("w5_I", I, 14);
      chk("w5_CI", CI, 1);
      chk("w5_D", D, 12'h0AB);

      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 1, 3, w3);
      cyc(0, 1, 1, 4, w4);
      cyc(0, 0, 0, 0, 0);
      status_in = 4'b0100;
      cyc(3, 0, 0, 0, 0);
      chk("w3_CC", CC_BAR, 1);
      cyc(4, 0, 0, 0, 0);
      chk("w4_CC", CC_BAR, 0);

      cyc(12'h040, 0, 0, 0, 0);
      chk("oob_I", I, 0);
      chk("oob_CCEN", CCEN_BAR, 1);
      chk("oob_set", oob_err, 1);
      cyc(1, 0, 0, 0, 0);
      chk("oob_sticky", oob_err, 1);

      cyc(2, 0, 1, 7, w7);
      chk("runld_ack", ld_ack, 0);
      cyc(7, 0, 0, 0, 0);
      chk("runld_I", I, 0);
      chk("runld_D", D, 0);

      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 1, 9, w9);
      cyc(0, 0, 0, 0, 0);
      cyc(9, 0, 0, 0, 0);
      chk("w9_I", I, 8);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 0, 0, 0);
         chk("bub_I", I, 14);
         chk("bub_held", held, 1);
      end
      cyc(0, 0, 0, 0, 0);
      chk("w9_re_I", I, 8);
      chk("w9_re_D", D, 12'h055);

      cyc(0, 1, 0, 0, 0);
      hold    = 1'b1;
      ld_en   = 1'b1;
      ld_addr = 10;
      ld_data = w10;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_I", I, 0);
      chk("arst_CCEN", CCEN_BAR, 1);
      chk("arst_held", held, 0);
      chk("arst_oob", oob_err, 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      cyc(10, 0, 0, 0, 0);
      cyc(10, 0, 0, 0, 0);
      chk("abandon_I", I, 0);
      chk("abandon_D", D, 0);

      begin
         int hold_left;
         hold_left = 0;
         for (int n = 0; n < 3000; n++) begin
            logic [11:0] y;
            logic        h;
            y = ($urandom_range(0, 11) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
            if (hold_left == 0 && $urandom_range(0, 4) == 0) hold_left = $urandom_range(1, 6);
            h = (hold_left != 0);
            if (hold_left != 0) hold_left--;
            status_in = 4'($urandom);
            rst       = ($urandom_range(0, 149) == 0);
            cyc(y, h, 1'($urandom), 6'($urandom), 23'($urandom));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
